// File: rtl/wgt_pingpong_sched.sv
// Layer-level scheduler for the weight path. It sequences img2col weight chunks
// into a two-bank ping-pong buffer and hands full banks to the cubic array.
module wgt_pingpong_sched #(
  parameter int CHN_W = 3,
  parameter int KS_W  = 4
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             layer_start,
  input  logic [CHN_W-1:0] cfg_chn_one_time,
  input  logic [CHN_W-1:0] cfg_chn_rpt_times,
  input  logic [KS_W-1:0]  cfg_kernel_size,
  output logic             i2c_wgt_start,
  output logic             i2c_wgt_continue,
  output logic [CHN_W-1:0] i2c_chn_one_time,
  output logic [CHN_W-1:0] i2c_chn_rpt_times,
  output logic [KS_W-1:0]  i2c_kernel_size,
  input  logic             chn_one_time_done,
  input  logic             chn_rpt_done,
  output logic             wr_bank_sel,
  output logic             rd_bank_sel,
  output logic             cube_wgt_valid,
  input  logic             cube_wgt_done,
  output logic             layer_busy,
  output logic             layer_done,
  output logic             proto_err
);

  // One extra bit so a full count of 2**CHN_W chunks fits.
  localparam int CNT_W = CHN_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_WAIT_BANK,
    S_DRAIN
  } state_t;

  state_t           state;
  logic [1:0]       bank_full;
  logic [CNT_W-1:0] chunk_cnt;
  logic [CNT_W-1:0] total;

  logic             rel_ok;
  logic             fill_done;
  logic             last_chunk;
  logic             wr_alt;
  logic             rd_nxt;
  logic             err_now;
  logic [1:0]       full_nxt;
  logic [CNT_W-1:0] chunk_nxt;

  // Bank occupancy after this cycle's producer and consumer events. The
  // release is applied first so a same-cycle set on the same bank wins.
  always_comb begin
    // NOTE: every always_comb target gets a default first, so no path can
    // leave a value held over and infer a latch.
    rel_ok     = cube_wgt_done & bank_full[rd_bank_sel];
    fill_done  = (state == S_FILL) & chn_one_time_done;
    chunk_nxt  = chunk_cnt + CNT_W'(1);
    last_chunk = fill_done & (chunk_nxt == total);
    wr_alt     = ~wr_bank_sel;
    rd_nxt     = rel_ok ? ~rd_bank_sel : rd_bank_sel;
    full_nxt   = bank_full;
    if (rel_ok)    full_nxt[rd_bank_sel] = 1'b0;
    if (fill_done) full_nxt[wr_bank_sel] = 1'b1;
    err_now = (cube_wgt_done & ~bank_full[rd_bank_sel])
            | (chn_one_time_done & (state != S_FILL))
            | (chn_rpt_done & ~last_chunk)
            | (last_chunk & ~chn_rpt_done);
  end

  always_ff @(posedge clock) begin
    // NOTE: the reset is sampled on the clock edge like any other input; every
    // register here is small control state, so all of it is reset.
    if (!rst_n) begin
      state             <= S_IDLE;
      bank_full         <= 2'b00;
      chunk_cnt         <= '0;
      total             <= '0;
      i2c_wgt_start     <= 1'b0;
      i2c_wgt_continue  <= 1'b0;
      i2c_chn_one_time  <= '0;
      i2c_chn_rpt_times <= '0;
      i2c_kernel_size   <= '0;
      wr_bank_sel       <= 1'b0;
      rd_bank_sel       <= 1'b0;
      cube_wgt_valid    <= 1'b0;
      layer_busy        <= 1'b0;
      layer_done        <= 1'b0;
      proto_err         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; later assignments in this
      // block deliberately override the defaults written above them.
      i2c_wgt_start    <= 1'b0;
      i2c_wgt_continue <= 1'b0;
      layer_done       <= 1'b0;
      bank_full        <= full_nxt;
      rd_bank_sel      <= rd_nxt;
      cube_wgt_valid   <= full_nxt[rd_nxt];
      if (err_now) proto_err <= 1'b1;

      case (state)
        S_IDLE: begin
          if (layer_start) begin
            i2c_chn_one_time  <= cfg_chn_one_time;
            i2c_chn_rpt_times <= cfg_chn_rpt_times;
            i2c_kernel_size   <= cfg_kernel_size;
            total             <= {1'b0, cfg_chn_rpt_times} + CNT_W'(1);
            chunk_cnt         <= '0;
            bank_full         <= 2'b00;
            wr_bank_sel       <= 1'b0;
            rd_bank_sel       <= 1'b0;
            cube_wgt_valid    <= 1'b0;
            proto_err         <= 1'b0;
            i2c_wgt_start     <= 1'b1;
            layer_busy        <= 1'b1;
            state             <= S_FILL;
          end
        end

        S_FILL: begin
          if (fill_done) begin
            wr_bank_sel <= wr_alt;
            chunk_cnt   <= chunk_nxt;
            if (last_chunk) begin
              state <= S_DRAIN;
            end else if (!full_nxt[wr_alt]) begin
              i2c_wgt_continue <= 1'b1;
            end else begin
              state <= S_WAIT_BANK;
            end
          end
        end

        S_WAIT_BANK: begin
          if (!full_nxt[wr_bank_sel]) begin
            i2c_wgt_continue <= 1'b1;
            state            <= S_FILL;
          end
        end

        S_DRAIN: begin
          if (full_nxt == 2'b00) begin
            layer_done <= 1'b1;
            layer_busy <= 1'b0;
            state      <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wgt_pingpong_sched.sv
// Directed bench for wgt_pingpong_sched: a vector table for whole layers plus
// hand-written sequences for stalls, simultaneous events and mid-layer reset.
module tb_wgt_pingpong_sched;

  localparam int CHN_W = 3;
  localparam int KS_W  = 4;

  logic             clock = 1'b0;
  logic             rst_n = 1'b0;
  logic             layer_start = 1'b0;
  logic [CHN_W-1:0] cfg_chn_one_time = '0;
  logic [CHN_W-1:0] cfg_chn_rpt_times = '0;
  logic [KS_W-1:0]  cfg_kernel_size = '0;
  logic             chn_one_time_done = 1'b0;
  logic             chn_rpt_done = 1'b0;
  logic             cube_wgt_done = 1'b0;
  logic             i2c_wgt_start, i2c_wgt_continue;
  logic [CHN_W-1:0] i2c_chn_one_time, i2c_chn_rpt_times;
  logic [KS_W-1:0]  i2c_kernel_size;
  logic             wr_bank_sel, rd_bank_sel, cube_wgt_valid;
  logic             layer_busy, layer_done, proto_err;

  wgt_pingpong_sched #(.CHN_W(CHN_W), .KS_W(KS_W)) dut (
    .clock             (clock),
    .rst_n             (rst_n),
    .layer_start       (layer_start),
    .cfg_chn_one_time  (cfg_chn_one_time),
    .cfg_chn_rpt_times (cfg_chn_rpt_times),
    .cfg_kernel_size   (cfg_kernel_size),
    .i2c_wgt_start     (i2c_wgt_start),
    .i2c_wgt_continue  (i2c_wgt_continue),
    .i2c_chn_one_time  (i2c_chn_one_time),
    .i2c_chn_rpt_times (i2c_chn_rpt_times),
    .i2c_kernel_size   (i2c_kernel_size),
    .chn_one_time_done (chn_one_time_done),
    .chn_rpt_done      (chn_rpt_done),
    .wr_bank_sel       (wr_bank_sel),
    .rd_bank_sel       (rd_bank_sel),
    .cube_wgt_valid    (cube_wgt_valid),
    .cube_wgt_done     (cube_wgt_done),
    .layer_busy        (layer_busy),
    .layer_done        (layer_done),
    .proto_err         (proto_err)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Output vector order: {start, continue, wr_bank_sel, rd_bank_sel,
  //                       cube_wgt_valid, layer_busy, layer_done, proto_err}
  typedef struct packed {
    logic             ls;
    logic [CHN_W-1:0] rpt;
    logic             od;
    logic             rdn;
    logic             cd;
    logic [7:0]       exp;
  } vec_t;

  vec_t vecs[25];

  function automatic logic [7:0] outs();
    return {i2c_wgt_start, i2c_wgt_continue, wr_bank_sel, rd_bank_sel,
            cube_wgt_valid, layer_busy, layer_done, proto_err};
  endfunction

  function automatic logic [9:0] cfg_out();
    return {i2c_kernel_size, i2c_chn_rpt_times, i2c_chn_one_time};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, let the edge pass, then drop the pulses.
  task automatic tick(input logic ls, input logic [CHN_W-1:0] rpt,
                      input logic od, input logic rdn, input logic cd);
    layer_start       = ls;
    cfg_chn_rpt_times = rpt;
    chn_one_time_done = od;
    chn_rpt_done      = rdn;
    cube_wgt_done     = cd;
    @(posedge clock);
    #1;
    layer_start       = 1'b0;
    chn_one_time_done = 1'b0;
    chn_rpt_done      = 1'b0;
    cube_wgt_done     = 1'b0;
  endtask

  logic cont_seen;

  initial begin
    // total=4, fast consumer
    vecs[0]  = '{1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 8'b10000100};
    vecs[1]  = '{1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 8'b00000100};
    vecs[2]  = '{1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 8'b01101100};
    vecs[3]  = '{1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 8'b00110100};
    vecs[4]  = '{1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 8'b01011100};
    vecs[5]  = '{1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 8'b00000100};
    vecs[6]  = '{1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 8'b01101100};
    vecs[7]  = '{1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 8'b00110100};
    vecs[8]  = '{1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 8'b00011100};
    vecs[9]  = '{1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 8'b00000010};
    vecs[10] = '{1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 8'b00000000};
    // stray release while idle, then early chn_rpt_done on chunk 2 of 4
    vecs[11] = '{1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 8'b00000001};
    vecs[12] = '{1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 8'b00000001};
    vecs[13] = '{1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 8'b10000100};
    vecs[14] = '{1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 8'b00000100};
    vecs[15] = '{1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 8'b01101100};
    vecs[16] = '{1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 8'b00101100};
    vecs[17] = '{1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 8'b00001101};
    vecs[18] = '{1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 8'b01011101};
    vecs[19] = '{1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 8'b00000101};
    vecs[20] = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'b01101101};
    vecs[21] = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'b00001101};
    vecs[22] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'b00011101};
    vecs[23] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'b00000011};
    vecs[24] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'b00000001};

    // Reset state
    rst_n = 1'b0;
    tick(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    check("reset_outs", {24'd0, outs()}, 32'h0);
    check("reset_cfg", {22'd0, cfg_out()}, 32'h0);
    rst_n = 1'b1;
    tick(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    // Vector table
    cfg_chn_one_time = 3'd2;
    cfg_kernel_size  = 4'd3;
    for (int i = 0; i < 25; i++) begin
      tick(vecs[i].ls, vecs[i].rpt, vecs[i].od, vecs[i].rdn, vecs[i].cd);
      check($sformatf("vec%0d", i), {24'd0, outs()}, {24'd0, vecs[i].exp});
    end

    // total=1 with slow producer and consumer
    cfg_chn_one_time = 3'd5;
    cfg_kernel_size  = 4'd9;
    cont_seen = 1'b0;
    tick(1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    check("t1_start", {24'd0, outs()}, 32'b10000100);
    check("t1_cfg", {22'd0, cfg_out()}, {22'd0, 4'd9, 3'd0, 3'd5});
    cfg_chn_one_time = 3'd1;
    cfg_kernel_size  = 4'd2;
    repeat (9) begin
      tick(1'b0, 3'd7, 1'b0, 1'b0, 1'b0);
      cont_seen |= i2c_wgt_continue;
    end
    check("t1_cfg_held", {22'd0, cfg_out()}, {22'd0, 4'd9, 3'd0, 3'd5});
    tick(1'b0, 3'd7, 1'b1, 1'b1, 1'b0);
    check("t1_filled", {24'd0, outs()}, 32'b00101100);
    repeat (4) begin
      tick(1'b0, 3'd7, 1'b0, 1'b0, 1'b0);
      cont_seen |= i2c_wgt_continue;
    end
    tick(1'b0, 3'd7, 1'b0, 1'b0, 1'b1);
    check("t1_done", {24'd0, outs()}, 32'b00110010);
    check("t1_no_continue", {31'd0, cont_seen}, 32'd0);
    tick(1'b0, 3'd7, 1'b0, 1'b0, 1'b0);
    check("t1_idle", {24'd0, outs()}, 32'b00110000);

    // total=3, consumer stalled until cycle 50
    cont_seen = 1'b0;
    tick(1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    check("st_start", {24'd0, outs()}, 32'b10000100);
    repeat (2) tick(1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
    check("st_chunk1", {24'd0, outs()}, 32'b01101100);
    repeat (2) tick(1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
    check("st_wait", {24'd0, outs()}, 32'b00001100);
    for (int c = 7; c < 50; c++) begin
      tick(1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
      cont_seen |= i2c_wgt_continue;
    end
    check("st_stalled", {31'd0, cont_seen}, 32'd0);
    tick(1'b0, 3'd2, 1'b0, 1'b0, 1'b1);
    check("st_release", {24'd0, outs()}, 32'b01011100);
    repeat (2) tick(1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 3'd2, 1'b1, 1'b1, 1'b0);
    check("st_last", {24'd0, outs()}, 32'b00111100);
    tick(1'b0, 3'd2, 1'b0, 1'b0, 1'b1);
    check("st_drain1", {24'd0, outs()}, 32'b00101100);
    tick(1'b0, 3'd2, 1'b0, 1'b0, 1'b1);
    check("st_done", {24'd0, outs()}, 32'b00110010);

    // Chunk completes in the same cycle the new write bank is released
    tick(1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    check("sim_start", {24'd0, outs()}, 32'b10000100);
    tick(1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 3'd3, 1'b1, 1'b0, 1'b0);
    check("sim_chunk1", {24'd0, outs()}, 32'b01101100);
    tick(1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 3'd3, 1'b1, 1'b0, 1'b1);
    check("sim_both", {24'd0, outs()}, 32'b01011100);
    rst_n = 1'b0;
    tick(1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    check("sim_reset", {24'd0, outs()}, 32'h0);

    // Reset while waiting for a bank, then a clean layer
    cfg_chn_one_time = 3'd6;
    cfg_kernel_size  = 4'd11;
    tick(1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
    check("rst_wait", {24'd0, outs()}, 32'b00001100);
    rst_n = 1'b0;
    tick(1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    check("rst_outs", {24'd0, outs()}, 32'h0);
    check("rst_cfg", {22'd0, cfg_out()}, 32'h0);
    tick(1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
    check("rst_idle", {24'd0, outs()}, 32'h0);
    cfg_chn_one_time = 3'd1;
    cfg_kernel_size  = 4'd2;
    tick(1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    check("new_start", {24'd0, outs()}, 32'b10000100);
    check("new_cfg", {22'd0, cfg_out()}, {22'd0, 4'd2, 3'd0, 3'd1});
    tick(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    check("new_filled", {24'd0, outs()}, 32'b00101100);
    tick(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    check("new_done", {24'd0, outs()}, 32'b00110010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
